tmr_bus_arbiter: RTL



---
 rtl/tmr_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tmr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_bus_arbiter
//  Purpose  : Two-master round-robin arbiter in front of one peripheral-bus
//             slave port. It latches the winning command, drives it to the
//             slave and routes response/rdata/fault back to the winner. A
//             response watchdog turns a hung slave access into a faulted
//             response.
//  Ports    : clk, rstn            - clock, asynchronous active-low reset
//             m0_* / m1_*          - master command in (addr, w_rb, acc,
//                                    wdata, req) and response out (rdata,
//                                    resp, fault)
//             s_*                  - slave command out (addr, w_rb, acc,
//                                    wdata, req) and response in (rdata,
//                                    resp, fault)
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_bus_arbiter #(
   parameter int XLEN      = 32,
   parameter int BUS_WIDTH = 32,
   parameter int ACC_W     = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rstn,
   // master 0
   input  logic [XLEN-1:0]      m0_addr,
   input  logic                 m0_w_rb,
   input  logic [ACC_W-1:0]     m0_acc,
   input  logic [BUS_WIDTH-1:0] m0_wdata,
   input  logic                 m0_req,
   output logic [BUS_WIDTH-1:0] m0_rdata,
   output logic                 m0_resp,
   output logic                 m0_fault,
   // master 1
   input  logic [XLEN-1:0]      m1_addr,
   input  logic                 m1_w_rb,
   input  logic [ACC_W-1:0]     m1_acc,
   input  logic [BUS_WIDTH-1:0] m1_wdata,
   input  logic                 m1_req,
   output logic [BUS_WIDTH-1:0] m1_rdata,
   output logic                 m1_resp,
   output logic                 m1_fault,
   // slave
   output logic [XLEN-1:0]      s_addr,
   output logic                 s_w_rb,
   output logic [ACC_W-1:0]     s_acc,
   output logic [BUS_WIDTH-1:0] s_wdata,
   output logic                 s_req,
   input  logic [BUS_WIDTH-1:0] s_rdata,
   input  logic                 s_resp,
   input  logic                 s_fault
);

   // The counter only has to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last_grant;   // master granted most recently; also selects the response target
   logic [CNT_W-1:0] r_cnt;

   logic w_any_req;
   logic w_pick;
   logic w_timeout;

   assign w_any_req = m0_req | m1_req;
   // On a tie the master that did not win last time gets the bus.
   assign w_pick    = (m0_req & m1_req) ? ~r_last_grant : m1_req;
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         s_addr       <= '0;
         s_w_rb       <= 1'b0;
         s_acc        <= '0;
         s_wdata      <= '0;
         s_req        <= 1'b0;
         m0_rdata     <= '0;
         m0_resp      <= 1'b0;
         m0_fault     <= 1'b0;
         m1_rdata     <= '0;
         m1_resp      <= 1'b0;
         m1_fault     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  s_addr       <= w_pick ? m1_addr  : m0_addr;
                  s_w_rb       <= w_pick ? m1_w_rb  : m0_w_rb;
                  s_acc        <= w_pick ? m1_acc   : m0_acc;
                  s_wdata      <= w_pick ? m1_wdata : m0_wdata;
                  s_req        <= 1'b1;
                  r_last_grant <= w_pick;
                  r_cnt        <= '0;
                  r_state      <= BUSY;
               end
            end

            BUSY: begin
               // A real slave response wins over the watchdog in the same cycle.
               if (s_resp) begin
                  s_req   <= 1'b0;
                  r_state <= DONE;
                  if (r_last_grant) begin
                     m1_rdata <= s_rdata;
                     m1_fault <= s_fault;
                     m1_resp  <= 1'b1;
                  end else begin
                     m0_rdata <= s_rdata;
                     m0_fault <= s_fault;
                     m0_resp  <= 1'b1;
                  end
               end else if (w_timeout) begin
                  s_req   <= 1'b0;
                  r_state <= DONE;
                  if (r_last_grant) begin
                     m1_rdata <= '0;
                     m1_fault <= 1'b1;
                     m1_resp  <= 1'b1;
                  end else begin
                     m0_rdata <= '0;
                     m0_fault <= 1'b1;
                     m0_resp  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            DONE: begin
               // rdata is kept; only the one-cycle response/fault are cleared.
               m0_resp  <= 1'b0;
               m0_fault <= 1'b0;
               m1_resp  <= 1'b0;
               m1_fault <= 1'b0;
               r_state  <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
